aq_djpeg_rgb_writer: RTL and testbench
======================================

Name: aq_djpeg_rgb_writer

Overview:
- Sits directly downstream of the JPEG YCbCr->RGB converter.
- Takes one RGB888 pixel per cycle, tagged with absolute PixelX/PixelY, and clips pixels from MCU padding.
- Converts each pixel to RGB565 and packs horizontally-linear neighbours into 32-bit words addressed in a linear framebuffer.
- Buffers the words in a FIFO that drains through a valid/ready memory-write port, and tells the block scheduler when there is room for another block.

Parameters:
FIFO_DEPTH_LOG2, 9, log2 of FIFO entries; must be >= 9.
ADDR_W, 32, width of BaseAddress and WrAddress.

Ports:
clk  input  1  clock
rst  input  1  asynchronous active-low reset
InEnable  input  1  pixel valid this cycle; the upstream stage has no stall
InPixelX  input  16  pixel column
InPixelY  input  16  pixel row
InR  input  8  red
InG  input  8  green
InB  input  8  blue
ImageWidth  input  16  visible width W; static during a frame
ImageHeight  input  16  visible height H; static during a frame
BaseAddress  input  ADDR_W  framebuffer byte base; must be 4-byte aligned
ClearStatus  input  1  single-cycle pulse; clears Overflow
WrValid  output  1  write request
WrReady  input  1  memory accepts the request
WrAddress  output  ADDR_W  4-byte-aligned byte address
WrData  output  32  two RGB565 pixels; lower halfword = even linear index
WrStrb  output  4  byte enables
BlockReady  output  1  FIFO can absorb a full 256-pixel block
Overflow  output  1  sticky; a word was dropped
FrameDone  output  1  one-cycle pulse

Behaviour:
- Reset: asynchronous, active-low. All outputs 0, except BlockReady = 1. FIFO is emptied, held pixel discarded, pipeline valids cleared. Reset mid-frame drops all in-flight data without emitting partial words.
- Clock and reset: single clock domain; reset input named rst, clock named clk.
- Clip: a pixel with InPixelX >= W or InPixelY >= H is dropped. It counts as "no pixel" in stage C.
- Pipeline, one pixel per cycle, no stall:
  - Stage A registers the pixel, the clip flag, the RGB565 value and the product InPixelY*W (32-bit).
  - Stage B forms the linear index L = Y*W + X (32-bit) and the byte address BaseAddress + 2*L.
  - Stage C is the pairing register.
- RGB565 (default): {R[7:3], G[7:2], B[7:3]}.
- Stage C holds at most one pixel and performs at most one FIFO write per cycle:
  - New pixel, nothing held: if L is even, hold it; if L is odd, write it alone.
  - New pixel, held pixel is even and new L == held L + 1: write the merged word (strobe 1111) and clear the hold.
  - New pixel, any other held case: write the held pixel alone, then hold the new pixel.
  - No new pixel, something held: write the held pixel alone.
  - Lone pixel strobe: 0011 if L is even (data in [15:0]); 1100 if L is odd (data in [31:16]). Unused half is zero.
  - WrAddress = (BaseAddress + 2*L) with bits [1:0] cleared.
- FIFO:
  - Show-ahead, 2^FIFO_DEPTH_LOG2 entries; each entry holds address, data, strobe and a last-pixel tag.
  - WrValid = FIFO not empty. A transfer completes when WrValid && WrReady.
  - WrAddress, WrData and WrStrb hold stable while WrValid && !WrReady.
  - Write and read in the same cycle are allowed when full: the read frees the slot, so there is no overflow.
- Latency: a pixel that completes a word at input cycle t gives WrValid = 1 in cycle t+4 when the FIFO was empty. A held-then-idle-flushed pixel gives WrValid at t+5.
- Overflow: a FIFO write while the FIFO is full and not being read drops the word and sets Overflow. Overflow clears on ClearStatus; if set and clear happen in the same cycle, set wins.
- BlockReady = FIFO count <= DEPTH - 260 (256 worst-case words plus pipeline margin). The scheduler must not start a block while BlockReady is low.
- FrameDone: one-cycle pulse in the cycle the word containing pixel (W-1, H-1) completes its handshake.
- Width of 0 or height of 0: every pixel is clipped; no writes occur.

Optional Feature:
- Macro: AQ_DJPEG_RGB565_ROUND_EN.
- Defined: round-to-nearest with saturation before packing:
  - R5 = min(31, (R+4)>>3)
  - G6 = min(63, (G+2)>>2)
  - B5 = min(31, (B+4)>>3)
  - Example: R=0x0C gives R5=2 (truncation gives 1).
- Undefined: plain truncation as above.
- Latency is identical in both builds.

Test Plan:
- Merge: W=32, H=16, Base=0x1000, WrReady=1. Feed (0,0)=F8/FC/F8 then (1,0)=00/00/00 at cycles t and t+1. Expect one write in cycle t+5: addr 0x1000, data 0x0000FFFF, strobe 1111.
- Clip: W=20, block X-range 16..31, row 0. Expect words at 0x1020 and 0x1024 only, both strobe 1111; X=20..31 produce no writes.
- Odd width: W=3, H=2. Feed L=0..5 in raster order. Expect 3 words at 0x1000, 0x1004 and 0x1008, all strobe 1111; (2,0)+(0,1) merge. FrameDone pulses when the 0x1008 word completes its handshake.
- Lone pixel: single pixel (1,0), W=32. Expect addr 0x1000, strobe 1100, data[15:0]=0. Single pixel (2,0) then idle: strobe 0011 at addr 0x1004, one cycle later than a merged word.
- Back-pressure: WrReady=0, W=256, feed 5 full blocks (640 words).
  - BlockReady falls once count > 252.
  - Overflow sets at word 513 and FIFO count stays 512.
  - Then WrReady=1: exactly 512 words drain in order with stable data under stall.
  - ClearStatus then clears Overflow.
- Reset mid-block: assert rst at pixel 100 of a block. Expect WrValid=0, BlockReady=1 and Overflow=0 immediately; no partial word is emitted after reset release.

Source files
------------

// File: rtl/aq_djpeg_rgb_writer.sv
// RGB888 pixel -> RGB565 word packer; clips MCU padding, pairs adjacent pixels, FIFO to memory port.
// Latency t+4 (merged word) / t+5 (lone flushed) to WrValid; WrReady stalls only the FIFO. Rounding: AQ_DJPEG_RGB565_ROUND_EN.

module aq_djpeg_rgb_writer_fifo #(
  parameter int W          = 69,
  parameter int DEPTH_LOG2 = 9
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_wr_vld,
  input  logic [W-1:0]          i_wr_dat,
  input  logic                  i_rd_rdy,
  output logic                  o_rd_vld,
  output logic [W-1:0]          o_rd_dat,
  output logic                  o_full,
  output logic [DEPTH_LOG2:0]   o_count
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] LP_FULL = (DEPTH_LOG2+1)'(DEPTH);

  logic [W-1:0]          r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] r_wr_ptr;
  logic [DEPTH_LOG2-1:0] r_rd_ptr;
  logic [DEPTH_LOG2:0]   r_count;
  logic                  w_push;
  logic                  w_pop;

  assign o_rd_vld = (r_count != '0);
  assign o_full   = (r_count == LP_FULL);
  assign o_rd_dat = r_mem[r_rd_ptr];
  assign o_count  = r_count;
  assign w_pop    = o_rd_vld && i_rd_rdy;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign w_push   = i_wr_vld && (!o_full || w_pop);

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_wr_dat;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

module aq_djpeg_rgb_writer #(
  parameter int FIFO_DEPTH_LOG2 = 9,
  parameter int ADDR_W          = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              InEnable,
  input  logic [15:0]       InPixelX,
  input  logic [15:0]       InPixelY,
  input  logic [7:0]        InR,
  input  logic [7:0]        InG,
  input  logic [7:0]        InB,
  input  logic [15:0]       ImageWidth,
  input  logic [15:0]       ImageHeight,
  input  logic [ADDR_W-1:0] BaseAddress,
  input  logic              ClearStatus,
  output logic              WrValid,
  input  logic              WrReady,
  output logic [ADDR_W-1:0] WrAddress,
  output logic [31:0]       WrData,
  output logic [3:0]        WrStrb,
  output logic              BlockReady,
  output logic              Overflow,
  output logic              FrameDone
);
  localparam int LP_DEPTH = 1 << FIFO_DEPTH_LOG2;
  localparam logic [FIFO_DEPTH_LOG2:0] LP_BLK_THR = (FIFO_DEPTH_LOG2+1)'(LP_DEPTH - 260);

  typedef struct packed {
    logic [31:0]       l;
    logic [ADDR_W-1:0] addr;
    logic [15:0]       pix;
    logic              last;
  } pix_t;

  typedef struct packed {
    logic              last;
    logic [3:0]        strb;
    logic [31:0]       data;
    logic [ADDR_W-1:0] addr;
  } wr_ent_t;

  function automatic wr_ent_t f_lone(input logic [ADDR_W-1:0] addr, input logic odd,
                                     input logic [15:0] pix, input logic last);
    wr_ent_t e;
    e.addr = addr;
    e.last = last;
    e.strb = odd ? 4'b1100 : 4'b0011;
    e.data = odd ? {pix, 16'h0000} : {16'h0000, pix};
    return e;
  endfunction

  logic [15:0]       w_pix565;
  logic              w_clip;
  logic              w_last_px;
  logic [31:0]       w_prod;
  logic [31:0]       w_l;
  logic [ADDR_W-1:0] w_addr;
  logic              w_unused;

  logic              r_a_vld;
  logic [15:0]       r_a_x;
  logic [15:0]       r_a_pix;
  logic [31:0]       r_a_prod;
  logic              r_a_last;
  logic              r_b_vld;
  pix_t              r_b;
  logic              r_h_vld;
  pix_t              r_h;
  logic              r_c_vld;
  wr_ent_t           r_c_ent;
  logic              r_overflow;

  logic              w_c_wr;
  wr_ent_t           w_c_ent;
  logic              w_h_load;
  logic              w_h_nxt_vld;

  logic              w_rd_vld;
  logic [$bits(wr_ent_t)-1:0] w_rd_dat;
  wr_ent_t           w_head;
  logic              w_full;
  logic [FIFO_DEPTH_LOG2:0] w_count;

`ifdef AQ_DJPEG_RGB565_ROUND_EN
  logic [8:0] w_r_rnd;
  logic [8:0] w_g_rnd;
  logic [8:0] w_b_rnd;
  assign w_r_rnd  = {1'b0, InR} + 9'd4;
  assign w_g_rnd  = {1'b0, InG} + 9'd2;
  assign w_b_rnd  = {1'b0, InB} + 9'd4;
  // Bit 8 set means the rounded value reached 32/64 and must saturate.
  assign w_pix565 = {w_r_rnd[8] ? 5'd31 : w_r_rnd[7:3],
                     w_g_rnd[8] ? 6'd63 : w_g_rnd[7:2],
                     w_b_rnd[8] ? 5'd31 : w_b_rnd[7:3]};
  assign w_unused = ^{w_r_rnd[2:0], w_g_rnd[1:0], w_b_rnd[2:0], w_addr[1:0]};
`else
  assign w_pix565 = {InR[7:3], InG[7:2], InB[7:3]};
  assign w_unused = ^{InR[2:0], InG[1:0], InB[2:0], w_addr[1:0]};
`endif

  assign w_clip    = (InPixelX >= ImageWidth) || (InPixelY >= ImageHeight);
  assign w_last_px = (InPixelX == ImageWidth - 16'd1) && (InPixelY == ImageHeight - 16'd1);
  assign w_prod    = {16'h0000, InPixelY} * {16'h0000, ImageWidth};
  assign w_l       = r_a_prod + {16'h0000, r_a_x};
  assign w_addr    = BaseAddress + ADDR_W'({w_l, 1'b0});

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_a_vld  <= 1'b0;
      r_a_x    <= '0;
      r_a_pix  <= '0;
      r_a_prod <= '0;
      r_a_last <= 1'b0;
      r_b_vld  <= 1'b0;
      r_b      <= '0;
    end else begin
      r_a_vld  <= InEnable && !w_clip;
      r_a_x    <= InPixelX;
      r_a_pix  <= w_pix565;
      r_a_prod <= w_prod;
      r_a_last <= w_last_px;
      r_b_vld  <= r_a_vld;
      r_b.l    <= w_l;
      r_b.addr <= {w_addr[ADDR_W-1:2], 2'b00};
      r_b.pix  <= r_a_pix;
      r_b.last <= r_a_last;
    end
  end

  // Pairing: an even pixel waits one cycle for its odd neighbour.
  always_comb begin
    w_c_wr      = 1'b0;
    w_c_ent     = '0;
    w_h_load    = 1'b0;
    w_h_nxt_vld = r_h_vld;
    if (r_b_vld) begin
      if (!r_h_vld) begin
        if (r_b.l[0]) begin
          w_c_wr  = 1'b1;
          w_c_ent = f_lone(r_b.addr, 1'b1, r_b.pix, r_b.last);
        end else begin
          w_h_load    = 1'b1;
          w_h_nxt_vld = 1'b1;
        end
      end else if (!r_h.l[0] && (r_b.l == r_h.l + 32'd1)) begin
        w_c_wr       = 1'b1;
        w_c_ent.addr = r_h.addr;
        w_c_ent.data = {r_b.pix, r_h.pix};
        w_c_ent.strb = 4'b1111;
        w_c_ent.last = r_h.last || r_b.last;
        w_h_nxt_vld  = 1'b0;
      end else begin
        w_c_wr      = 1'b1;
        w_c_ent     = f_lone(r_h.addr, r_h.l[0], r_h.pix, r_h.last);
        w_h_load    = 1'b1;
        w_h_nxt_vld = 1'b1;
      end
    end else if (r_h_vld) begin
      w_c_wr      = 1'b1;
      w_c_ent     = f_lone(r_h.addr, r_h.l[0], r_h.pix, r_h.last);
      w_h_nxt_vld = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_h_vld    <= 1'b0;
      r_h        <= '0;
      r_c_vld    <= 1'b0;
      r_c_ent    <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_h_vld <= w_h_nxt_vld;
      if (w_h_load) r_h <= r_b;
      r_c_vld <= w_c_wr;
      r_c_ent <= w_c_ent;
      if (r_c_vld && w_full && !(w_rd_vld && WrReady)) r_overflow <= 1'b1;
      else if (ClearStatus)                              r_overflow <= 1'b0;
    end
  end

  aq_djpeg_rgb_writer_fifo #(
    .W          ($bits(wr_ent_t)),
    .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .i_wr_vld (r_c_vld),
    .i_wr_dat (r_c_ent),
    .i_rd_rdy (WrReady),
    .o_rd_vld (w_rd_vld),
    .o_rd_dat (w_rd_dat),
    .o_full   (w_full),
    .o_count  (w_count)
  );

  assign w_head     = w_rd_dat;
  assign WrValid    = w_rd_vld;
  assign WrAddress  = w_rd_vld ? w_head.addr : '0;
  assign WrData     = w_rd_vld ? w_head.data : '0;
  assign WrStrb     = w_rd_vld ? w_head.strb : '0;
  assign FrameDone  = w_rd_vld && WrReady && w_head.last;
  assign BlockReady = (w_count <= LP_BLK_THR);
  assign Overflow   = r_overflow;
endmodule

// File: tb/tb_aq_djpeg_rgb_writer.sv
// Directed bench for aq_djpeg_rgb_writer: merge, lone, clip, odd width, back-pressure, reset.
module tb_aq_djpeg_rgb_writer;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        InEnable = 1'b0;
  logic [15:0] InPixelX = '0;
  logic [15:0] InPixelY = '0;
  logic [7:0]  InR = '0;
  logic [7:0]  InG = '0;
  logic [7:0]  InB = '0;
  logic [15:0] ImageWidth = 16'd32;
  logic [15:0] ImageHeight = 16'd16;
  logic [31:0] BaseAddress = 32'h1000;
  logic        ClearStatus = 1'b0;
  logic        WrValid;
  logic        WrReady = 1'b1;
  logic [31:0] WrAddress;
  logic [31:0] WrData;
  logic [3:0]  WrStrb;
  logic        BlockReady;
  logic        Overflow;
  logic        FrameDone;

  aq_djpeg_rgb_writer dut (
    .clk(clk), .rst(rst), .InEnable(InEnable), .InPixelX(InPixelX), .InPixelY(InPixelY),
    .InR(InR), .InG(InG), .InB(InB), .ImageWidth(ImageWidth), .ImageHeight(ImageHeight),
    .BaseAddress(BaseAddress), .ClearStatus(ClearStatus), .WrValid(WrValid), .WrReady(WrReady),
    .WrAddress(WrAddress), .WrData(WrData), .WrStrb(WrStrb), .BlockReady(BlockReady),
    .Overflow(Overflow), .FrameDone(FrameDone)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  logic [31:0] q_addr[$];
  logic [31:0] q_data[$];
  logic [3:0]  q_strb[$];
  int          q_cyc[$];
  int          q_fd[$];

  always @(negedge clk) begin
    if (rst) begin
      if (WrValid && WrReady) begin
        q_addr.push_back(WrAddress);
        q_data.push_back(WrData);
        q_strb.push_back(WrStrb);
        q_cyc.push_back(cyc);
      end
      if (FrameDone) q_fd.push_back(cyc);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_word(input string tag, input int idx, input logic [31:0] ea,
                          input logic [31:0] ed, input logic [3:0] es, input int ec);
    if (idx >= q_addr.size()) begin
      chk({tag, "_present"}, 32'(q_addr.size()), 32'(idx + 1));
    end else begin
      chk({tag, "_addr"}, q_addr[idx], ea);
      chk({tag, "_data"}, q_data[idx], ed);
      chk({tag, "_strb"}, 32'(q_strb[idx]), 32'(es));
      if (ec >= 0) chk({tag, "_cycle"}, 32'(q_cyc[idx]), 32'(ec));
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle(input int n);
    InEnable = 1'b0;
    tick(n);
  endtask

  task automatic px(input logic [15:0] x, input logic [15:0] y,
                    input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    InEnable = 1'b1;
    InPixelX = x;
    InPixelY = y;
    InR = r;
    InG = g;
    InB = b;
    tick(1);
  endtask

  // Colour chosen so both truncation and rounding reproduce p exactly.
  task automatic px565(input int x, input int y, input logic [15:0] p);
    px(16'(x), 16'(y), {p[15:11], 3'b000}, {p[10:5], 2'b00}, {p[4:0], 3'b000});
  endtask

  task automatic clrq();
    q_addr.delete();
    q_data.delete();
    q_strb.delete();
    q_cyc.delete();
    q_fd.delete();
  endtask

  int t0;
  logic [31:0] exp_round;

  initial begin
    rst = 1'b0;
    tick(3);
    chk("reset_wrvalid",    32'(WrValid),    32'd0);
    chk("reset_blockready", 32'(BlockReady), 32'd1);
    chk("reset_overflow",   32'(Overflow),   32'd0);
    chk("reset_framedone",  32'(FrameDone),  32'd0);
    chk("reset_wrstrb",     32'(WrStrb),     32'd0);
    chk("reset_wraddr",     WrAddress,       32'd0);
    rst = 1'b1;
    tick(2);

    clrq();
    t0 = cyc;
    px(0, 0, 8'hF8, 8'hFC, 8'hF8);
    px(1, 0, 8'h00, 8'h00, 8'h00);
    idle(12);
    chk("merge_count", 32'(q_addr.size()), 32'd1);
    chk_word("merge", 0, 32'h1000, 32'h0000FFFF, 4'hF, t0 + 5);

    clrq();
    t0 = cyc;
    px(1, 0, 8'h10, 8'h20, 8'h30);
    idle(12);
    chk("lone_odd_count", 32'(q_addr.size()), 32'd1);
    chk_word("lone_odd", 0, 32'h1000, 32'h11060000, 4'hC, t0 + 4);

    clrq();
    t0 = cyc;
    px(2, 0, 8'h08, 8'h04, 8'h08);
    idle(12);
    chk("lone_even_count", 32'(q_addr.size()), 32'd1);
    chk_word("lone_even", 0, 32'h1004, 32'h00000821, 4'h3, t0 + 5);

`ifdef AQ_DJPEG_RGB565_ROUND_EN
    exp_round = 32'h10000000;
`else
    exp_round = 32'h08000000;
`endif
    clrq();
    px(3, 0, 8'h0C, 8'h00, 8'h00);
    idle(12);
    chk_word("rgb565_r0c", 0, 32'h1004, exp_round, 4'hC, -1);

    ImageWidth = 16'd20;
    clrq();
    for (int x = 16; x < 32; x++) px(16'(x), 0, 8'h00, 8'h00, 8'h00);
    idle(15);
    chk("clip_count", 32'(q_addr.size()), 32'd2);
    chk_word("clip_w0", 0, 32'h1020, 32'h0, 4'hF, -1);
    chk_word("clip_w1", 1, 32'h1024, 32'h0, 4'hF, -1);

    ImageWidth = 16'd3;
    ImageHeight = 16'd2;
    clrq();
    t0 = cyc;
    for (int i = 0; i < 6; i++) px565(i % 3, i / 3, 16'(i));
    idle(15);
    chk("oddw_count", 32'(q_addr.size()), 32'd3);
    chk_word("oddw_w0", 0, 32'h1000, 32'h00010000, 4'hF, -1);
    chk_word("oddw_w1", 1, 32'h1004, 32'h00030002, 4'hF, -1);
    chk_word("oddw_w2", 2, 32'h1008, 32'h00050004, 4'hF, t0 + 9);
    chk("oddw_framedone_count", 32'(q_fd.size()), 32'd1);
    if (q_fd.size() > 0) chk("oddw_framedone_cycle", 32'(q_fd[0]), 32'(t0 + 9));

    ImageWidth = 16'd256;
    ImageHeight = 16'd8;
    WrReady = 1'b0;
    clrq();
    for (int l = 0; l < 504; l++) px565(l % 256, l / 256, 16'(l));
    idle(8);
    chk("bp_blockready_252", 32'(BlockReady), 32'd1);
    chk("bp_wrvalid",        32'(WrValid),    32'd1);
    for (int l = 504; l < 506; l++) px565(l % 256, l / 256, 16'(l));
    idle(8);
    chk("bp_blockready_253", 32'(BlockReady), 32'd0);
    for (int l = 506; l < 1024; l++) px565(l % 256, l / 256, 16'(l));
    idle(8);
    chk("bp_overflow_512", 32'(Overflow), 32'd0);
    for (int l = 1024; l < 1280; l++) px565(l % 256, l / 256, 16'(l));
    idle(8);
    chk("bp_overflow_513", 32'(Overflow), 32'd1);
    chk("stall_addr_a", WrAddress,       32'h1000);
    chk("stall_data_a", WrData,          32'h00010000);
    chk("stall_strb_a", 32'(WrStrb),     32'hF);
    idle(20);
    chk("stall_addr_b", WrAddress,       32'h1000);
    chk("stall_data_b", WrData,          32'h00010000);
    chk("stall_strb_b", 32'(WrStrb),     32'hF);
    chk("stall_no_xfer", 32'(q_addr.size()), 32'd0);
    WrReady = 1'b1;
    idle(600);
    chk("drain_count", 32'(q_addr.size()), 32'd512);
    for (int k = 0; k < 512; k++)
      chk_word($sformatf("drain_w%0d", k), k, 32'h1000 + 32'(4 * k),
               {16'(2 * k + 1), 16'(2 * k)}, 4'hF, -1);
    chk("drain_overflow_sticky", 32'(Overflow),   32'd1);
    chk("drain_blockready",      32'(BlockReady), 32'd1);
    chk("drain_wrvalid",         32'(WrValid),    32'd0);
    ClearStatus = 1'b1;
    tick(1);
    ClearStatus = 1'b0;
    chk("clear_overflow", 32'(Overflow), 32'd0);

    ImageWidth = 16'd32;
    ImageHeight = 16'd16;
    WrReady = 1'b0;
    clrq();
    for (int i = 0; i < 100; i++) px565(i % 32, i / 32, 16'(i));
    chk("rstmid_pre_wrvalid", 32'(WrValid), 32'd1);
    InEnable = 1'b1;
    InPixelX = 16'd4;
    InPixelY = 16'd3;
    #2 rst = 1'b0;
    #1;
    chk("rstmid_wrvalid",    32'(WrValid),    32'd0);
    chk("rstmid_blockready", 32'(BlockReady), 32'd1);
    chk("rstmid_overflow",   32'(Overflow),   32'd0);
    tick(2);
    InEnable = 1'b0;
    rst = 1'b1;
    WrReady = 1'b1;
    idle(20);
    chk("rstmid_no_words", 32'(q_addr.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
